// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared widths, mem_op encodings (must match exe's mem_op_o) and FSM states.
package mem_access_pkg;
  localparam int RADDR_WIDTH = 5;
  localparam int RDATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam logic [RADDR_WIDTH-1:0] ZERO_REG = '0;
  localparam logic [RDATA_WIDTH-1:0] ZERO = '0;
  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB = 4'd1;
  localparam logic [3:0] MEM_LH = 4'd2;
  localparam logic [3:0] MEM_LW = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SB = 4'd6;
  localparam logic [3:0] MEM_SH = 4'd7;
  localparam logic [3:0] MEM_SW = 4'd8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  function automatic logic is_mem(logic [3:0] op);
    return op inside {[MEM_LB:MEM_SW]};
  endfunction
  function automatic logic is_load(logic [3:0] op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction
  function automatic logic is_store(logic [3:0] op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane enables, store data steering, load extension and alignment check.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [3:0]            op_i,
  input  logic [1:0]            a_i,
  input  logic [DATA_WIDTH-1:0] sdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [3:0]            be_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] ldata_o,
  output logic                  misalign_o
);
  logic is_b, is_h, is_w;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    is_b = op_i inside {MEM_LB, MEM_LBU, MEM_SB};
    is_h = op_i inside {MEM_LH, MEM_LHU, MEM_SH};
    is_w = op_i inside {MEM_LW, MEM_SW};
    b = rdata_i[{a_i, 3'b000} +: 8];
    h = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o = is_b ? 4'b0001 << a_i : is_h ? (a_i[1] ? 4'b1100 : 4'b0011) : is_w ? 4'b1111 : 4'b0000;
    wdata_o = is_b ? {4{sdata_i[7:0]}} : is_h ? {2{sdata_i[15:0]}} : sdata_i;
    misalign_o = (is_h && a_i[0]) || (is_w && a_i != 2'b00);
    ldata_o = op_i == MEM_LB  ? {{24{b[7]}}, b} :
              op_i == MEM_LBU ? {24'b0, b} :
              op_i == MEM_LH  ? {{16{h[15]}}, h} :
              op_i == MEM_LHU ? {16'b0, h} : rdata_i;
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM-stage data-memory initiator with req/ack bus, pipeline stall and timeout.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
  input  logic                   mem_we_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic [3:0]             mem_op_i,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [RDATA_WIDTH-1:0] reg_wdata_o,
  output logic                   stallreq_o,
  output logic                   misalign_o,
  output logic                   bus_err_o,
  output logic                   dbus_req_o,
  output logic                   dbus_we_o,
  output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
  output logic [3:0]             dbus_be_o,
  output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
  input  logic [DATA_WIDTH-1:0]  dbus_rdata_i,
  input  logic                   dbus_ack_i
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d, be_q, be_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, ld_q, ld_d;
  logic [RADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic we_q, we_d, rwe_q, rwe_d, err_q, err_d, req_q, req_d;
  logic idle, busy, done, op_ok, mis, start, ack, tmo;
  logic [3:0] cur_op, be;
  logic [1:0] cur_a;
  logic [DATA_WIDTH-1:0] wdata, ldata;
  // In IDLE the aligner sees the incoming op; afterwards it sees the latched one for load extension.
  mem_lane_align u_align (
    .op_i(cur_op), .a_i(cur_a), .sdata_i(mem_data_i), .rdata_i(dbus_rdata_i),
    .be_o(be), .wdata_o(wdata), .ldata_o(ldata), .misalign_o(mis)
  );
  always_comb begin
    idle = state_q == S_IDLE;
    busy = state_q == S_BUSY;
    done = state_q == S_DONE;
    cur_op = idle ? mem_op_i : op_q;
    cur_a = idle ? mem_addr_i[1:0] : addr_q[1:0];
    op_ok = is_mem(mem_op_i);
    start = idle && op_ok && !mis;
    ack = busy && dbus_ack_i;
    tmo = busy && !dbus_ack_i && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    state_d = busy ? ((ack || tmo) ? S_DONE : S_BUSY) : start ? S_BUSY : S_IDLE;
    cnt_d = busy ? cnt_q + 1'b1 : '0;
    op_d = start ? mem_op_i : op_q;
    addr_d = start ? mem_addr_i : addr_q;
    be_d = start ? be : be_q;
    wdata_d = start ? wdata : wdata_q;
    we_d = start ? (is_store(mem_op_i) || (mem_we_i && !is_load(mem_op_i))) : we_q;
    waddr_d = start ? reg_waddr_i : waddr_q;
    rwe_d = start ? reg_we_i : rwe_q;
    ld_d = ack ? ldata : ld_q;
    err_d = tmo;
    req_d = start || (busy && !ack && !tmo);
    reg_waddr_o = rst_i ? ZERO_REG : done ? waddr_q : reg_waddr_i;
    reg_wdata_o = rst_i ? ZERO : done ? ld_q : reg_wdata_i;
    reg_we_o = !rst_i && (done ? rwe_q && is_load(op_q) && !err_q : idle && !op_ok && reg_we_i);
    stallreq_o = !rst_i && (start || busy);
    misalign_o = !rst_i && idle && op_ok && mis;
    bus_err_o = !rst_i && done && err_q;
    dbus_req_o = req_q;
    dbus_we_o = req_q && we_q;
    dbus_addr_o = req_q ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    dbus_be_o = req_q ? be_q : 4'b0000;
    dbus_wdata_o = req_q ? wdata_q : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      op_q <= MEM_NOP;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      waddr_q <= ZERO_REG;
      rwe_q <= 1'b0;
      ld_q <= '0;
      err_q <= 1'b0;
      req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      rwe_q <= rwe_d;
      ld_q <= ld_d;
      err_q <= err_d;
      req_q <= req_d;
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed vectors with hand-computed expectations for mem_access.
module tb_mem_access;
  import mem_access_pkg::*;
  logic clk = 0, rst_i = 1;
  logic [4:0] reg_waddr_i = 0, reg_waddr_o;
  logic reg_we_i = 0, reg_we_o, mem_we_i = 0;
  logic [31:0] reg_wdata_i = 0, reg_wdata_o, mem_addr_i = 0, mem_data_i = 0;
  logic [3:0] mem_op_i = 0, dbus_be_o;
  logic stallreq_o, misalign_o, bus_err_o, dbus_req_o, dbus_we_o, dbus_ack_i = 0;
  logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i = 0;
  int n_chk = 0, n_pass = 0;
  mem_access dut (
    .clk_i(clk), .rst_i(rst_i), .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i),
    .reg_wdata_i(reg_wdata_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_op_i(mem_op_i), .reg_waddr_o(reg_waddr_o),
    .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o), .stallreq_o(stallreq_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .dbus_req_o(dbus_req_o),
    .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] wa, input logic we, input logic [31:0] wd);
    mem_op_i = op;
    mem_addr_i = addr;
    mem_data_i = data;
    mem_we_i = is_store(op);
    reg_waddr_i = wa;
    reg_we_i = we;
    reg_wdata_i = wd;
    #1;
  endtask
  task automatic txn(input string tag, input logic [3:0] op, input logic [31:0] addr,
                     input logic [31:0] data, input logic [31:0] rdata, input int lat,
                     input logic [3:0] ebe, input logic [31:0] ewd, input logic ewe,
                     input logic [31:0] eres, input logic erwe);
    int stalls;
    drive(op, addr, data, 5'd7, erwe, 32'h55);
    chk({tag, ".idle_we"}, reg_we_o, 0);
    stalls = stallreq_o;
    for (int i = 0; i < lat; i++) begin
      step;
      chk({tag, ".req"}, dbus_req_o, 1);
      chk({tag, ".addr"}, dbus_addr_o, {addr[31:2], 2'b00});
      chk({tag, ".be"}, dbus_be_o, ebe);
      chk({tag, ".we"}, dbus_we_o, ewe);
      if (ewe) chk({tag, ".wdata"}, dbus_wdata_o, ewd);
      stalls += stallreq_o;
      if (i == lat - 1) begin
        dbus_ack_i = 1;
        dbus_rdata_i = rdata;
      end
    end
    step;
    dbus_ack_i = 0;
    dbus_rdata_i = 32'h0;
    #1;
    chk({tag, ".done_req"}, dbus_req_o, 0);
    chk({tag, ".done_stall"}, stallreq_o, 0);
    chk({tag, ".done_rwe"}, reg_we_o, erwe);
    chk({tag, ".done_err"}, bus_err_o, 0);
    if (erwe) begin
      chk({tag, ".res"}, reg_wdata_o, eres);
      chk({tag, ".waddr"}, reg_waddr_o, 7);
    end
    chk({tag, ".stall_cycles"}, stalls, lat + 1);
    drive(MEM_NOP, 0, 0, 0, 0, 0);
    step;
  endtask
  initial begin
    int n;
    drive(MEM_NOP, 0, 0, 5'd9, 1, 32'h77);
    step;
    step;
    chk("rst.req", dbus_req_o, 0);
    chk("rst.stall", stallreq_o, 0);
    chk("rst.we", reg_we_o, 0);
    chk("rst.waddr", reg_waddr_o, 0);
    chk("rst.wdata", reg_wdata_o, 0);
    rst_i = 0;
    drive(MEM_NOP, 0, 0, 5'd5, 1, 32'h1234);
    chk("nop.we", reg_we_o, 1);
    chk("nop.wdata", reg_wdata_o, 32'h1234);
    chk("nop.waddr", reg_waddr_o, 5);
    chk("nop.stall", stallreq_o, 0);
    drive(4'd12, 32'h100, 0, 5'd6, 1, 32'h99);
    chk("bad_op.stall", stallreq_o, 0);
    chk("bad_op.we", reg_we_o, 1);
    dbus_ack_i = 1;
    step;
    dbus_ack_i = 0;
    chk("idle_ack.req", dbus_req_o, 0);
    drive(MEM_NOP, 0, 0, 0, 0, 0);
    step;
    txn("sw", MEM_SW, 32'h100, 32'hDEADBEEF, 32'h0, 1, 4'b1111, 32'hDEADBEEF, 1, 0, 0);
    txn("lb", MEM_LB, 32'h103, 32'h0, 32'h80112233, 3, 4'b1000, 0, 0, 32'hFFFFFF80, 1);
    txn("lbu", MEM_LBU, 32'h103, 32'h0, 32'h80112233, 3, 4'b1000, 0, 0, 32'h00000080, 1);
    txn("sh", MEM_SH, 32'h202, 32'h0000ABCD, 32'h0, 2, 4'b1100, 32'hABCDABCD, 1, 0, 0);
    txn("lhu", MEM_LHU, 32'h202, 32'h0, 32'hABCD1234, 1, 4'b1100, 0, 0, 32'h0000ABCD, 1);
    txn("lh", MEM_LH, 32'h202, 32'h0, 32'hABCD1234, 2, 4'b1100, 0, 0, 32'hFFFFABCD, 1);
    txn("sb", MEM_SB, 32'h101, 32'h000000A5, 32'h0, 1, 4'b0010, 32'hA5A5A5A5, 1, 0, 0);
    txn("lh0", MEM_LH, 32'h200, 32'h0, 32'h1234F00D, 1, 4'b0011, 0, 0, 32'hFFFFF00D, 1);
    drive(MEM_LW, 32'h101, 0, 5'd3, 1, 32'h5);
    chk("mis.flag", misalign_o, 1);
    chk("mis.stall", stallreq_o, 0);
    chk("mis.we", reg_we_o, 0);
    step;
    chk("mis.req", dbus_req_o, 0);
    drive(MEM_LH, 32'h201, 0, 5'd3, 1, 32'h5);
    chk("mis_h.flag", misalign_o, 1);
    drive(MEM_NOP, 0, 0, 0, 0, 0);
    chk("mis.clear", misalign_o, 0);
    step;
    chk("mis.req2", dbus_req_o, 0);
    drive(MEM_LW, 32'h300, 0, 5'd8, 1, 32'h0);
    n = 0;
    step;
    while (dbus_req_o === 1'b1 && n < 40) begin
      n++;
      step;
    end
    chk("tmo.req_cycles", n, 16);
    chk("tmo.err", bus_err_o, 1);
    chk("tmo.we", reg_we_o, 0);
    chk("tmo.stall", stallreq_o, 0);
    drive(MEM_NOP, 0, 0, 0, 0, 0);
    step;
    chk("tmo.err_clear", bus_err_o, 0);
    drive(MEM_LW, 32'h400, 0, 5'd8, 1, 32'h0);
    step;
    chk("rstb.req", dbus_req_o, 1);
    rst_i = 1;
    #1;
    chk("rstb.stall", stallreq_o, 0);
    step;
    chk("rstb.req_off", dbus_req_o, 0);
    rst_i = 0;
    drive(MEM_NOP, 0, 0, 0, 0, 0);
    dbus_ack_i = 1;
    dbus_rdata_i = 32'h12345678;
    step;
    dbus_ack_i = 0;
    #1;
    chk("rstb.late_ack_req", dbus_req_o, 0);
    chk("rstb.late_ack_we", reg_we_o, 0);
    chk("rstb.late_ack_stall", stallreq_o, 0);
    drive(MEM_NOP, 0, 0, 5'd3, 1, 32'h11);
    chk("b2b.add1_we", reg_we_o, 1);
    chk("b2b.add1_data", reg_wdata_o, 32'h11);
    step;
    drive(MEM_LW, 32'h104, 0, 5'd4, 1, 32'h0);
    chk("b2b.lw_stall0", stallreq_o, 1);
    step;
    chk("b2b.lw_stall1", stallreq_o, 1);
    dbus_ack_i = 1;
    dbus_rdata_i = 32'hCAFEF00D;
    step;
    dbus_ack_i = 0;
    #1;
    chk("b2b.lw_we", reg_we_o, 1);
    chk("b2b.lw_waddr", reg_waddr_o, 4);
    chk("b2b.lw_data", reg_wdata_o, 32'hCAFEF00D);
    chk("b2b.lw_stall2", stallreq_o, 0);
    step;
    drive(MEM_NOP, 0, 0, 5'd5, 1, 32'h22);
    chk("b2b.add2_we", reg_we_o, 1);
    chk("b2b.add2_waddr", reg_waddr_o, 5);
    chk("b2b.add2_data", reg_wdata_o, 32'h22);
    chk("b2b.add2_stall", stallreq_o, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
